// File: rtl/uart_tx_scheduler_if.sv
// Byte-requester bus for uart_tx_scheduler: per-requester valid/data with a
// one-hot ready pulse returned by the scheduler.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding a single 8N1 UART transmitter paced by baud_tick.
// Optional even-parity bit is enabled by defining UART_TX_SCHED_PARITY_EN.
module uart_tx_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int STOP_BITS = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       baud_tick,
    uart_tx_scheduler_if.slave         req_bus,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_REQ - 1);
    localparam logic            LAST_STOP = 1'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ALIGN  = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
`ifdef UART_TX_SCHED_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif
    localparam logic [2:0] S_STOP   = 3'd5;

    logic [2:0]      state_reg,    state_next;
    logic            tx_reg,       tx_next;
    logic            busy_reg,     busy_next;
    logic [7:0]      shift_reg,    shift_next;
    logic [2:0]      bit_cnt_reg,  bit_cnt_next;
    logic            stop_cnt_reg, stop_cnt_next;
    logic [ID_W-1:0] grant_id_reg, grant_id_next;
    logic [ID_W-1:0] ptr_reg,      ptr_next;
`ifdef UART_TX_SCHED_PARITY_EN
    logic            parity_reg,   parity_next;
`endif

    // Release of reset is re-timed so the first grant never races the reset edge.
    logic rst_meta_reg;
    logic rst_sync_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_reg <= 1'b0;
            rst_sync_reg <= 1'b0;
        end else begin
            rst_meta_reg <= 1'b1;
            rst_sync_reg <= rst_meta_reg;
        end
    end

    logic [ID_W-1:0]    rot_idx [NUM_REQ];
    logic [NUM_REQ-1:0] rot_valid;
    logic [7:0]         byte_arr [NUM_REQ];
    logic [ID_W-1:0]    grant_idx;
    logic               grant_found;
    logic               accept;

    // rot_valid[k] is the request k places after the pointer, wrapping modulo NUM_REQ.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        logic [ID_W:0] rot_sum;
        assign rot_sum       = {1'b0, ptr_reg} + (ID_W+1)'(gi);
        assign rot_idx[gi]   = (rot_sum >= NUM_REQ_W) ? ID_W'(rot_sum - NUM_REQ_W)
                                                      : rot_sum[ID_W-1:0];
        assign rot_valid[gi] = req_bus.req_valid[rot_idx[gi]];
        assign byte_arr[gi]  = req_bus.req_data[8*gi +: 8];
        assign req_bus.req_ready[gi] = accept && (grant_idx == ID_W'(gi));
    end

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                grant_found = 1'b1;
                grant_idx   = rot_idx[k];
            end
        end
    end

    assign accept = (state_reg == S_IDLE) && grant_found && rst_sync_reg;

    always_comb begin
        state_next    = state_reg;
        tx_next       = tx_reg;
        busy_next     = busy_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        grant_id_next = grant_id_reg;
        ptr_next      = ptr_reg;
`ifdef UART_TX_SCHED_PARITY_EN
        parity_next   = parity_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                tx_next = 1'b1;
                if (accept) begin
                    shift_next    = byte_arr[grant_idx];
                    grant_id_next = grant_idx;
                    ptr_next      = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                    busy_next     = 1'b1;
                    state_next    = S_ALIGN;
`ifdef UART_TX_SCHED_PARITY_EN
                    parity_next   = ^byte_arr[grant_idx];
`endif
                end
            end
            S_ALIGN: begin
                if (baud_tick) begin
                    tx_next    = 1'b0;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    tx_next      = shift_reg[0];
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_cnt_next = 3'd0;
                    state_next   = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_reg == 3'd7) begin
`ifdef UART_TX_SCHED_PARITY_EN
                        tx_next       = parity_reg;
                        state_next    = S_PARITY;
`else
                        tx_next       = 1'b1;
                        stop_cnt_next = 1'b0;
                        state_next    = S_STOP;
`endif
                    end else begin
                        tx_next      = shift_reg[0];
                        shift_next   = {1'b0, shift_reg[7:1]};
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
            end
`ifdef UART_TX_SCHED_PARITY_EN
            S_PARITY: begin
                if (baud_tick) begin
                    tx_next       = 1'b1;
                    stop_cnt_next = 1'b0;
                    state_next    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_reg == LAST_STOP) begin
                        busy_next  = 1'b0;
                        state_next = S_IDLE;
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end
            end
            default: begin
                tx_next    = 1'b1;
                busy_next  = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    // An asserted reset abandons any frame in flight and forces the line high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            grant_id_reg <= '0;
            ptr_reg      <= '0;
`ifdef UART_TX_SCHED_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            grant_id_reg <= grant_id_next;
            ptr_reg      <= ptr_next;
`ifdef UART_TX_SCHED_PARITY_EN
            parity_reg   <= parity_next;
`endif
        end
    end

    assign tx       = tx_reg;
    assign busy     = busy_reg;
    assign grant_id = grant_id_reg;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed, table-driven bench for uart_tx_scheduler (NUM_REQ=4); parity and
// two-stop-bit frames are covered when UART_TX_SCHED_PARITY_EN is defined.
module tb_uart_tx_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
`ifdef UART_TX_SCHED_PARITY_EN
    localparam int PAR       = 1;
    localparam int STOP_BITS = 2;
`else
    localparam int PAR       = 0;
    localparam int STOP_BITS = 1;
`endif
    localparam int NBITS = 9 + PAR + STOP_BITS;

    logic            clk       = 1'b0;
    logic            reset_n   = 1'b0;
    logic            baud_tick = 1'b0;
    logic            tx;
    logic            busy;
    logic [ID_W-1:0] grant_id;

    uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_scheduler #(
        .NUM_REQ   (NUM_REQ),
        .STOP_BITS (STOP_BITS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .baud_tick (baud_tick),
        .req_bus   (bus),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    // One baud tick every fourth clock, driven on the falling edge.
    initial begin : tick_gen
        int cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            baud_tick = (cyc % 4 == 0);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [1:0]  exp_grant;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t        vecs [11];
    int          passed = 0;
    int          total  = 0;
    logic [11:0] last_bits;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            if (baud_tick) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
        if (!seen) check("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic start_frame(input logic [3:0] valid, input logic [31:0] data,
                               input logic [1:0] exp_grant);
        logic [3:0] rdy;
        logic [3:0] exp_rdy;
        bit         seen;
        @(negedge clk);
        bus.req_valid = valid;
        bus.req_data  = data;
        seen = 1'b0;
        rdy  = '0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (bus.req_ready != 4'd0) begin
                seen = 1'b1;
                rdy  = bus.req_ready;
                break;
            end
            @(negedge clk);
        end
        if (!seen) check("ready_timeout", 32'd0, 32'd1);
        exp_rdy = 4'b0001 << exp_grant;
        check("req_ready", 32'(rdy), 32'(exp_rdy));
        @(posedge clk);
        #1;
        check("ready_pulse", 32'(bus.req_ready), 32'd0);
        check("busy_rise", 32'(busy), 32'd1);
        check("grant_id", 32'(grant_id), 32'(exp_grant));
        check("align_tx", 32'(tx), 32'd1);
    endtask

    task automatic collect_frame(input logic [7:0] exp_byte);
        logic [11:0] exp_bits;
        logic [11:0] got;
        exp_bits      = '1;
        exp_bits[0]   = 1'b0;
        exp_bits[8:1] = exp_byte;
`ifdef UART_TX_SCHED_PARITY_EN
        exp_bits[9]   = ^exp_byte;
`endif
        got = '1;
        for (int b = 0; b < NBITS; b++) begin
            wait_tick();
            got[b] = tx;
        end
        check("busy_last_bit", 32'(busy), 32'd1);
        check("frame_bits", 32'(got), 32'(exp_bits));
        wait_tick();
        check("busy_fall", 32'(busy), 32'd0);
        check("idle_tx", 32'(tx), 32'd1);
        last_bits = got;
        $display("frame byte=%02h grant=%0d bits=%03h", exp_byte, grant_id, got);
    endtask

    initial begin
        // Round robin from reset, single byte, pointer wrap, back-to-back re-grant.
        vecs[0]  = '{4'b1111, 32'h13121110, 2'd0, 8'h10};
        vecs[1]  = '{4'b1111, 32'h13121110, 2'd1, 8'h11};
        vecs[2]  = '{4'b1111, 32'h13121110, 2'd2, 8'h12};
        vecs[3]  = '{4'b1111, 32'h13121110, 2'd3, 8'h13};
        vecs[4]  = '{4'b1111, 32'h13121110, 2'd0, 8'h10};
        vecs[5]  = '{4'b0001, 32'h000000A5, 2'd0, 8'hA5};
        vecs[6]  = '{4'b0100, 32'h003C0000, 2'd2, 8'h3C};
        vecs[7]  = '{4'b1010, 32'h66005500, 2'd3, 8'h66};
        vecs[8]  = '{4'b1010, 32'h66005500, 2'd1, 8'h55};
        vecs[9]  = '{4'b0001, 32'h000000C3, 2'd0, 8'hC3};
        vecs[10] = '{4'b0001, 32'h0000003E, 2'd0, 8'h3E};

        bus.req_valid = 4'b1111;
        bus.req_data  = 32'h13121110;
        reset_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);

        @(negedge clk);
        bus.req_valid = 4'b0000;
        reset_n       = 1'b1;
        repeat (3) wait_tick();
        check("idle_tick_tx", 32'(tx), 32'd1);
        check("idle_tick_busy", 32'(busy), 32'd0);

        for (int v = 0; v < 11; v++) begin
            start_frame(vecs[v].valid, vecs[v].data, vecs[v].exp_grant);
            collect_frame(vecs[v].exp_byte);
        end

        // Reset while data bit 4 (a zero) is on the line.
        start_frame(4'b0100, 32'h000F0000, 2'd2);
        repeat (6) wait_tick();
        check("pre_reset_tx", 32'(tx), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_grant", 32'(grant_id), 32'd0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        start_frame(4'b0100, 32'h00A60000, 2'd2);
        collect_frame(8'hA6);

`ifdef UART_TX_SCHED_PARITY_EN
        start_frame(4'b0001, 32'h00000007, 2'd0);
        collect_frame(8'h07);
        check("parity_07", 32'(last_bits[9]), 32'd1);
        start_frame(4'b0001, 32'h00000003, 2'd0);
        collect_frame(8'h03);
        check("parity_03", 32'(last_bits[9]), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
